halt_dump_unit: RTL and testbench

- Hardware reader that complements the program/data preload path.
- When the CPU signals halt, it walks data memory words 0..MEM_WORDS-1 and then registers 0..REG_COUNT-1, streaming each value out over a valid/ready interface.
- Sits beside `CPU`, using the memory module's spare read port and the decode module's register-file debug read port.
- Gives board builds the same end-of-run dump the simulation benches print.

---
 rtl/halt_dump_unit_if.sv | 38 +++
 rtl/halt_dump_unit.sv | 202 ++++++++++++++++++++
 tb/tb_halt_dump_unit.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/halt_dump_unit_if.sv
// halt_dump_unit_if -- output stream of the halt dump unit.
//
// Carries one dumped word per beat using a valid/ready handshake. A beat is
// transferred on a rising clock edge where out_valid && out_ready.
//   out_valid  producer -> consumer  beat fields below are valid
//   out_ready  consumer -> producer  consumer accepts the beat
//   out_data   producer -> consumer  dumped value
//   out_tag    producer -> consumer  0 = memory word, 1 = register
//   out_index  producer -> consumer  memory address or register number
//   out_last   producer -> consumer  final beat of the dump
interface halt_dump_unit_if #(
  parameter int DATA_W = 16
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_tag;
  logic [7:0]        out_index;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_tag,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_tag,
    input  out_index,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/halt_dump_unit.sv
// halt_dump_unit -- end-of-run dump of data memory and register file.
//
// When the CPU halt indicator falls, the unit walks data-memory words
// 0..MEM_WORDS-1 and then registers 0..REG_COUNT-1, streaming each value over
// the out_bus valid/ready interface. The dump runs exactly once per reset.
//
// Ports:
//   CLK        system clock
//   rst        synchronous active-high reset
//   do_halt    CPU halt indicator; a 1->0 transition starts the dump
//   mem_addr   data-memory read address (synchronous read, 1-cycle latency)
//   mem_rdata  data-memory read data
//   reg_addr   register-file debug read address
//   reg_rdata  register-file read data, combinational from reg_addr
//   out_bus    output stream (master side)
//   busy       high from trigger until the last beat is accepted
//   done       high after a completed dump, held until rst
module halt_dump_unit #(
  parameter int MEM_WORDS = 16,
  parameter int REG_COUNT = 8,
  parameter int DATA_W    = 16
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic                do_halt,
  output logic [7:0]          mem_addr,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [2:0]          reg_addr,
  input  logic [DATA_W-1:0]   reg_rdata,
  halt_dump_unit_if.master    out_bus,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    IDLE,
    MEM_REQ,
    MEM_WAIT,
    MEM_SEND,
    REG_SEND,
    DONE
  } state_t;

  localparam logic [7:0] MEM_LAST = 8'(MEM_WORDS - 1);
  localparam logic [7:0] REG_LAST = 8'(REG_COUNT - 1);

  state_t            state_reg, state_next;
  logic              halt_q_reg;
  logic [7:0]        idx_reg, idx_next;
  logic [7:0]        mem_addr_reg, mem_addr_next;
  logic [2:0]        reg_addr_reg, reg_addr_next;
  // Low on the first REG_SEND cycle, which captures register 0.
  logic              reg_loaded_reg, reg_loaded_next;
  logic              out_valid_reg, out_valid_next;
  logic [DATA_W-1:0] out_data_reg, out_data_next;
  logic              out_tag_reg, out_tag_next;
  logic [7:0]        out_index_reg, out_index_next;
  logic              out_last_reg, out_last_next;

  logic              trigger;
  logic              accept;
  logic [7:0]        idx_inc;
  logic              reg_lookahead;

  assign trigger = halt_q_reg & ~do_halt;
  assign accept  = out_valid_reg & out_bus.out_ready;
  assign idx_inc = idx_reg + 8'd1;

  // To sustain one register beat per cycle, the register file is addressed
  // with the next index during the accepting cycle, so its data is ready to be
  // captured at the same edge. While stalled the address stays at idx.
  assign reg_lookahead = (state_reg == REG_SEND) && reg_loaded_reg &&
                         accept && !out_last_reg;

  assign mem_addr = mem_addr_reg;
  assign reg_addr = reg_lookahead ? idx_inc[2:0] : reg_addr_reg;

  assign out_bus.out_valid = out_valid_reg;
  assign out_bus.out_data  = out_data_reg;
  assign out_bus.out_tag   = out_tag_reg;
  assign out_bus.out_index = out_index_reg;
  assign out_bus.out_last  = out_last_reg;

  assign busy = (state_reg != IDLE) && (state_reg != DONE);
  assign done = (state_reg == DONE);

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    mem_addr_next   = mem_addr_reg;
    reg_addr_next   = reg_addr_reg;
    reg_loaded_next = reg_loaded_reg;
    out_valid_next  = out_valid_reg;
    out_data_next   = out_data_reg;
    out_tag_next    = out_tag_reg;
    out_index_next  = out_index_reg;
    out_last_next   = out_last_reg;

    case (state_reg)
      IDLE: begin
        if (trigger) begin
          idx_next      = 8'd0;
          mem_addr_next = 8'd0;
          state_next    = MEM_REQ;
        end
      end

      // mem_addr already holds idx; the memory samples it at the end of
      // this cycle.
      MEM_REQ: begin
        state_next = MEM_WAIT;
      end

      MEM_WAIT: begin
        out_data_next  = mem_rdata;
        out_valid_next = 1'b1;
        out_tag_next   = 1'b0;
        out_index_next = idx_reg;
        out_last_next  = 1'b0;
        state_next     = MEM_SEND;
      end

      MEM_SEND: begin
        if (accept) begin
          out_valid_next = 1'b0;
          if (idx_reg == MEM_LAST) begin
            idx_next        = 8'd0;
            reg_addr_next   = 3'd0;
            reg_loaded_next = 1'b0;
            state_next      = REG_SEND;
          end else begin
            idx_next      = idx_inc;
            mem_addr_next = idx_inc;
            state_next    = MEM_REQ;
          end
        end
      end

      REG_SEND: begin
        if (!reg_loaded_reg) begin
          out_data_next   = reg_rdata;
          out_valid_next  = 1'b1;
          out_tag_next    = 1'b1;
          out_index_next  = idx_reg;
          out_last_next   = (idx_reg == REG_LAST);
          reg_loaded_next = 1'b1;
        end else if (accept) begin
          if (out_last_reg) begin
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
            state_next     = DONE;
          end else begin
            // reg_rdata already reflects idx+1 through the lookahead address.
            idx_next       = idx_inc;
            reg_addr_next  = idx_inc[2:0];
            out_data_next  = reg_rdata;
            out_index_next = idx_inc;
            out_last_next  = (idx_inc == REG_LAST);
          end
        end
      end

      // Terminal until rst: later halt edges are ignored.
      DONE: begin
        out_valid_next = 1'b0;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_reg      <= IDLE;
      halt_q_reg     <= 1'b0;
      idx_reg        <= 8'd0;
      mem_addr_reg   <= 8'd0;
      reg_addr_reg   <= 3'd0;
      reg_loaded_reg <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_tag_reg    <= 1'b0;
      out_index_reg  <= 8'd0;
      out_last_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      halt_q_reg     <= do_halt;
      idx_reg        <= idx_next;
      mem_addr_reg   <= mem_addr_next;
      reg_addr_reg   <= reg_addr_next;
      reg_loaded_reg <= reg_loaded_next;
      out_valid_reg  <= out_valid_next;
      out_data_reg   <= out_data_next;
      out_tag_reg    <= out_tag_next;
      out_index_reg  <= out_index_next;
      out_last_reg   <= out_last_next;
    end
  end

endmodule

// File: tb/tb_halt_dump_unit.sv
// tb_halt_dump_unit -- directed bench for halt_dump_unit.
//
// A small synchronous memory and a combinational register file are preloaded;
// a negedge monitor records every transferred beat and watches that stalled
// beats stay constant. Each test task compares against hand-computed values.
module tb_halt_dump_unit;
  localparam int DATA_W    = 16;
  localparam int MEM_WORDS = 16;
  localparam int REG_COUNT = 8;
  localparam int NBEATS    = MEM_WORDS + REG_COUNT;

  typedef struct packed {
    logic        tag;
    logic [7:0]  idx;
    logic [15:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        do_halt;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic [2:0]  reg_addr;
  logic [15:0] reg_rdata;
  logic        busy;
  logic        done;

  halt_dump_unit_if #(.DATA_W(DATA_W)) bus ();

  halt_dump_unit #(
    .MEM_WORDS(MEM_WORDS),
    .REG_COUNT(REG_COUNT),
    .DATA_W(DATA_W)
  ) dut (
    .CLK(clk),
    .rst(rst),
    .do_halt(do_halt),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .reg_addr(reg_addr),
    .reg_rdata(reg_rdata),
    .out_bus(bus),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  logic [15:0] mem  [0:255];
  logic [15:0] regs [0:7];
  logic [15:0] exp_data [0:NBEATS-1];

  always @(posedge clk) mem_rdata <= mem[mem_addr];
  assign reg_rdata = regs[reg_addr];

  int    vectors     = 0;
  int    miscompares = 0;
  int    cyc         = 0;
  int    ready_mode  = 0;  // 0: ready high, 1: high one cycle in three, 2: low
  beat_t beats[$];
  beat_t stall_snap;
  bit    stall_armed = 1'b0;
  int    stall_err   = 0;
  int    stall_cnt   = 0;

  function automatic beat_t cur_beat();
    return {bus.out_tag, bus.out_index, bus.out_data, bus.out_last};
  endfunction

  function automatic beat_t exp_beat(input int k);
    if (k < MEM_WORDS)
      return {1'b0, 8'(k), exp_data[k], 1'b0};
    return {1'b1, 8'(k - MEM_WORDS), exp_data[k], (k == NBEATS - 1)};
  endfunction

  // Monitor: sampled mid-cycle; a beat with valid && ready && !rst here is
  // transferred at the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (stall_armed) begin
        stall_cnt++;
        if (cur_beat() !== stall_snap || bus.out_valid !== 1'b1) stall_err++;
      end
      stall_armed = bus.out_valid && !bus.out_ready && !rst;
      stall_snap  = cur_beat();
      if (bus.out_valid && bus.out_ready && !rst) beats.push_back(cur_beat());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    case (ready_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = (cyc % 3 == 0);
      default: bus.out_ready = 1'b0;
    endcase
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    do_halt = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    beats.delete();
  endtask

  // Leaves do_halt low right after an edge; the next edge sees the trigger.
  task automatic pulse_halt();
    do_halt = 1'b1;
    tick();
    do_halt = 1'b0;
  endtask

  task automatic wait_dump(input string name);
    bit ok = 1'b0;
    logic prev_done = 1'b0;
    for (int t = 0; t < 400; t++) begin
      prev_done = done;
      tick();
      if (beats.size() >= NBEATS) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s timeout: beats=%0d required=%0d", name, beats.size(), NBEATS);
    end else if ({prev_done, done, busy} !== 3'b010) begin
      miscompares++;
      $display("FAIL %s done_edge: prev_done,done,busy=%b required=010", name,
               {prev_done, done, busy});
    end
  endtask

  task automatic check_beats(input string name);
    vectors++;
    if (beats.size() !== NBEATS) begin
      miscompares++;
      $display("FAIL %s beat_count: got %0d required %0d", name, beats.size(), NBEATS);
    end
    for (int k = 0; k < NBEATS && k < beats.size(); k++) begin
      vectors++;
      if (beats[k] !== exp_beat(k)) begin
        miscompares++;
        $display("FAIL %s beat%0d: got tag=%0d idx=%0d data=%0d last=%0d required tag=%0d idx=%0d data=%0d last=%0d",
                 name, k, beats[k].tag, beats[k].idx, beats[k].data, beats[k].last,
                 exp_beat(k).tag, exp_beat(k).idx, exp_beat(k).data, exp_beat(k).last);
      end
    end
    $display("%s: %0d beats collected", name, beats.size());
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({bus.out_valid, bus.out_last, bus.out_tag, bus.out_index, bus.out_data,
         busy, done, mem_addr, reg_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_values: valid=%b last=%b tag=%b index=%0d data=%0d busy=%b done=%b mem_addr=%0d reg_addr=%0d required all 0",
               bus.out_valid, bus.out_last, bus.out_tag, bus.out_index, bus.out_data,
               busy, done, mem_addr, reg_addr);
    end
    $display("test_reset done");
  endtask

  task automatic test_no_trigger();
    do_reset();
    ready_mode = 0;
    for (int i = 0; i < 60; i++) tick();
    vectors++;
    if (beats.size() !== 0) begin
      miscompares++;
      $display("FAIL no_trigger beats: got %0d required 0", beats.size());
    end
    vectors++;
    if ({busy, done, bus.out_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL no_trigger status: busy,done,valid=%b required 000", {busy, done, bus.out_valid});
    end
    $display("test_no_trigger done");
  endtask

  task automatic test_latency();
    do_reset();
    ready_mode = 0;
    pulse_halt();   // do_halt falls at edge N
    tick();         // after N+1
    vectors++;
    if ({busy, mem_addr, bus.out_valid} !== {1'b1, 8'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL latency_n1: busy=%b mem_addr=%0d valid=%b required 1 0 0", busy, mem_addr, bus.out_valid);
    end
    tick();         // after N+2
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_n2: valid=%b required 0", bus.out_valid);
    end
    tick();         // after N+3
    vectors++;
    if ({bus.out_valid, bus.out_tag, bus.out_index, bus.out_data} !== {1'b1, 1'b0, 8'd0, 16'd30000}) begin
      miscompares++;
      $display("FAIL latency_n3: valid=%b tag=%b index=%0d data=%0d required 1 0 0 30000",
               bus.out_valid, bus.out_tag, bus.out_index, bus.out_data);
    end
    tick(); tick(); tick();   // after N+6: second memory beat
    vectors++;
    if ({bus.out_valid, bus.out_index, bus.out_data} !== {1'b1, 8'd1, 16'd10}) begin
      miscompares++;
      $display("FAIL latency_n6: valid=%b index=%0d data=%0d required 1 1 10",
               bus.out_valid, bus.out_index, bus.out_data);
    end
    $display("test_latency done");
  endtask

  task automatic test_full_dump();
    do_reset();
    ready_mode = 0;
    pulse_halt();
    wait_dump("full");
    check_beats("full");
  endtask

  task automatic test_stall();
    do_reset();
    ready_mode = 1;
    stall_err  = 0;
    stall_cnt  = 0;
    pulse_halt();
    wait_dump("stall");
    check_beats("stall");
    vectors++;
    if (stall_err !== 0) begin
      miscompares++;
      $display("FAIL stall_stable: %0d changed cycles required 0", stall_err);
    end
    vectors++;
    if ((stall_cnt > 0) !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_seen: stalled cycles=%0d required >0", stall_cnt);
    end
    ready_mode = 0;
  endtask

  task automatic test_retrigger();
    do_reset();
    ready_mode = 0;
    pulse_halt();
    for (int t = 0; t < 100 && beats.size() < 5; t++) tick();
    pulse_halt();   // second falling edge during the memory phase
    wait_dump("retrig");
    pulse_halt();   // falling edge after done
    for (int i = 0; i < 40; i++) tick();
    check_beats("retrig");
    vectors++;
    if ({done, busy, bus.out_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL retrig_status: done,busy,valid=%b required 100", {done, busy, bus.out_valid});
    end
  endtask

  task automatic test_reset_mid_dump();
    bit found = 1'b0;
    do_reset();
    ready_mode = 0;
    pulse_halt();
    for (int t = 0; t < 200; t++) begin
      tick();
      if (bus.out_valid && bus.out_tag == 1'b0 && bus.out_index == 8'd5) begin
        ready_mode = 2;
        bus.out_ready = 1'b0;
        found = 1'b1;
        break;
      end
    end
    vectors++;
    if (found !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid reach_idx5: found=%b required 1", found);
    end
    tick(); tick(); tick();
    // Reset lands while the idx5 beat is offered with ready high.
    rst = 1'b1;
    ready_mode = 0;
    bus.out_ready = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({bus.out_valid, busy, done, bus.out_index, bus.out_data, mem_addr} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid outputs: valid=%b busy=%b done=%b index=%0d data=%0d mem_addr=%0d required all 0",
               bus.out_valid, busy, done, bus.out_index, bus.out_data, mem_addr);
    end
    vectors++;
    if (beats.size() !== 5) begin
      miscompares++;
      $display("FAIL rst_mid transferred: got %0d beats required 5", beats.size());
    end
    beats.delete();
    pulse_halt();
    wait_dump("rst_mid");
    check_beats("rst_mid");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    do_halt = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 16'd0;
    for (int i = 0; i < 8; i++) regs[i] = 16'd0;
    mem[0]  = 16'd30000;
    mem[1]  = 16'd10;
    mem[15] = 16'h00FF;
    regs[1] = 16'd245;
    regs[2] = 16'd29890;
    regs[7] = 16'hBEEF;

    for (int k = 0; k < NBEATS; k++) exp_data[k] = 16'd0;
    exp_data[0]  = 16'd30000;
    exp_data[1]  = 16'd10;
    exp_data[15] = 16'd255;
    exp_data[17] = 16'd245;
    exp_data[18] = 16'd29890;
    exp_data[23] = 16'd48879;

    test_reset();
    test_no_trigger();
    test_latency();
    test_full_dump();
    test_stall();
    test_retrigger();
    test_reset_mid_dump();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
